rriot_timer: RTL and testbench
==============================

# rriot_timer

Interval-timer and IRQ-pin controller for the MCS6530 replacement. Sits beside the `mcs6530` core, sampled on `phi2` like every other registered pad. It owns the programmable countdown timer: divide select, prescaler, underflow flag and interrupt enable. It drives the `IRQ`/`IRQ_EN` pair that takes over PB7 in the top-level pad mux.

## Interface
- `CNT_W`, default 8: timer count width.
- `PRE_W`, default 10: prescaler width; must hold 1023.
- `phi2` in 1: sole clock; all state changes on its rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `sel` in 1: timer register access this cycle (core's decoded timer select qualified by `CS1`/`RS0`).
- `we_n` in 1: 0 = write, 1 = read; meaningful only with `sel`.
- `A` in 4: low address bits `A[3:0]` of the access.
- `DI` in 8: write data.
- `DO` out 8: read data, combinational from `A` and current state.
- `IRQ` out 1: PB7 drive level; 0 = interrupt asserted.
- `IRQ_EN` out 1: PB7 owned by timer when 1.

## Operation
- **Write** (`sel & ~we_n`):
  - `count <= DI`.
  - `div <= A[1:0]`: 00 = ÷1, 01 = ÷8, 10 = ÷64, 11 = ÷1024.
  - `pre <=` divisor−1.
  - `flag <= 0`, `irq_en <= A[3]`, `post <= 0`.
- **Read timer** (`sel & we_n & ~A[0]`):
  - `DO = count`.
  - `flag <= 0`, `irq_en <= A[3]`.
  - Count and prescaler continue undisturbed.
- **Read flag** (`sel & we_n & A[0]`):
  - `DO = {flag, 7'b0}`.
  - No state change; the flag is not cleared.
- **Tick**, on any cycle without a write:
  - If `pre != 0`: `pre <= pre−1`.
  - Otherwise: reload `pre` with divisor−1, or with 0 when `post`, and step the count.
  - Step: if `count != 0`, `count <= count−1`.
  - Step with `count == 0` (underflow): `count <= 8'hFF`, `flag <= 1`, `post <= 1`.
- **Post-underflow mode** (`post = 1`): count decrements every cycle (÷1) until the next write, so software can read elapsed time since expiry.
- **Interrupt outputs**:
  - `IRQ = ~(flag & irq_en)`.
  - `IRQ_EN = irq_en`.
- **Decode**: `A[2]` and `A[1]` are don't-care for reads; decoding them is the core's job via `sel`.
- **Idle read data**: `DO` is 8'h00 when `sel = 0`.

## Timing
- **Reset** (`rst_n = 0` at a `phi2` edge): `count = 0`, `pre = 0`, `div = 00`, `flag = 0`, `post = 0`, `irq_en = 0`. Outputs: `IRQ = 1`, `IRQ_EN = 0`, `DO = 0`.
- **Reset mid-count**: aborts immediately; no flag is left pending.
- **Write latency**: a write at edge t makes `count = N` visible from t+1. The first decrement occurs at edge t+D (D = divisor). Underflow (`flag` set) occurs at edge t+D·(N+1).
- **Divisor examples**: N = 0 with ÷1 sets the flag at t+1. With ÷1024 and N = 0, it sets at t+1024.
- **Flag clear**: a timer read at edge t clears `flag` at t+1. `IRQ` returns high the same cycle `flag` drops.
- **Underflow vs write**: a write wins. The flag stays 0, the new count loads and `post` clears.
- **Underflow vs timer read**: set wins. `DO` shows 8'h00 that cycle and `flag = 1` afterwards. Software must re-read to acknowledge.
- **Wrap-around**: in post mode, count continues FF→00→FF. The flag is set again at each 00→FF wrap; re-setting an already-set flag is a no-op.
- **Enable without flag**: `irq_en` changes take effect at the next edge. With `flag = 0`, enabling drives `IRQ = 1`.

## Structure
- **Shared package `rriot_pkg`**:
  - `div_sel_e` enum: DIV1, DIV8, DIV64, DIV1024.
  - Function `div_reload(div_sel_e)` returning 0/7/63/1023.
  - Address bit constants `A_IRQEN = 3` and `A_FLAGSEL = 0`.
- **Sub-module `rriot_prescaler`**:
  - Holds `pre` and the reload/`post` logic.
  - Emits a one-cycle `step` pulse.
  - The parent holds `count`, `flag`, `irq_en` and the access decode.

## Test plan
- Reset held 3 cycles, then released → `IRQ = 1`, `IRQ_EN = 0`, `DO = 0`, timer read returns 8'h00.
- Write 8'h03, `A = 4'b1001` (÷8, IRQ enabled) → count 03 until t+8, flag and `IRQ = 0` at t+32, then count FF, FE, … every cycle.
- Write 8'h02 with ÷1024, no enable → flag read shows 8'h80 at t+3072, `IRQ` stays 1. Timer read with `A[3] = 1` → `irq_en` set, flag cleared, `IRQ = 1`.
- Underflow cycle coincident with timer read → `DO = 8'h00`, flag = 1 after the edge, `IRQ` low.
- Write 8'h10 on the exact underflow edge of a running count → flag remains 0 and count = 8'h10 at the next cycle.
- `rst_n` low mid-count (÷64, count 8'h40) → everything at reset values on the next edge; no flag after release.

Source files
------------

// File: rtl/rriot_pkg.sv
// Shared types and constants for the RRIOT interval timer: divide-select
// encoding, prescaler reload values and the address bits the timer decodes.
package rriot_pkg;

    typedef enum logic [1:0] {
        DIV1    = 2'd0,
        DIV8    = 2'd1,
        DIV64   = 2'd2,
        DIV1024 = 2'd3
    } div_sel_e;

    localparam int A_IRQEN   = 3;
    localparam int A_FLAGSEL = 0;

    // Prescaler reload is divisor-1 so that a step lands every D cycles.
    function automatic logic [9:0] div_reload(input div_sel_e d);
        logic [9:0] r;
        case (d)
            DIV1:    r = 10'd0;
            DIV8:    r = 10'd7;
            DIV64:   r = 10'd63;
            DIV1024: r = 10'd1023;
            default: r = 10'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rriot_timer_if.sv
// Register-access and IRQ-pin bundle between the mcs6530 core and the timer.
interface rriot_timer_if;
    logic       sel;
    logic       we_n;
    logic [3:0] A;
    logic [7:0] DI;
    logic [7:0] DO;
    logic       IRQ;
    logic       IRQ_EN;

    modport master (output sel, we_n, A, DI, input DO, IRQ, IRQ_EN);
    modport slave  (input sel, we_n, A, DI, output DO, IRQ, IRQ_EN);
endinterface

// File: rtl/rriot_prescaler.sv
// Timer prescaler: holds the divide select, the prescale counter and the
// post-underflow mode bit; emits a one-cycle step pulse for the count.
module rriot_prescaler
    import rriot_pkg::*;
#(
    parameter int PRE_W = 10
) (
    input  logic     phi2,
    input  logic     rst_n,
    input  logic     load_i,
    input  div_sel_e div_i,
    input  logic     zero_i,
    output logic     step_o
);

    logic [PRE_W-1:0] pre_q, pre_d;
    div_sel_e         div_q, div_d;
    logic             post_q, post_d;

    // State register with synchronous active-low reset.
    always_ff @(posedge phi2) begin
        if (!rst_n) begin
            pre_q  <= {PRE_W{1'b0}};
            div_q  <= DIV1;
            post_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            div_q  <= div_d;
            post_q <= post_d;
        end
    end

    // Reload on write; otherwise count down and step on zero. An underflow
    // (step with count zero) drops straight into divide-by-one mode.
    always_comb begin
        pre_d  = pre_q;
        div_d  = div_q;
        post_d = post_q;
        step_o = 1'b0;
        if (load_i) begin
            div_d  = div_i;
            pre_d  = PRE_W'(div_reload(div_i));
            post_d = 1'b0;
        end else if (pre_q != {PRE_W{1'b0}}) begin
            pre_d = pre_q - PRE_W'(1);
        end else begin
            step_o = 1'b1;
            if (post_q || zero_i) begin
                pre_d = {PRE_W{1'b0}};
            end else begin
                pre_d = PRE_W'(div_reload(div_q));
            end
            if (zero_i) begin
                post_d = 1'b1;
            end else begin
                post_d = post_q;
            end
        end
    end

endmodule

// File: rtl/rriot_timer.sv
// MCS6530 interval timer: count register, underflow flag, interrupt enable,
// register access decode and the IRQ/IRQ_EN pair that takes over PB7.
module rriot_timer
    import rriot_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int PRE_W = 10
) (
    input  logic         phi2,
    input  logic         rst_n,
    rriot_timer_if.slave bus
);

    logic [CNT_W-1:0] count_q, count_d;
    logic             flag_q, flag_d;
    logic             irq_en_q, irq_en_d;
    logic             wr_s, rd_tmr_s, rd_flag_s, step_s, zero_s;

    assign wr_s      = bus.sel & ~bus.we_n;
    assign rd_tmr_s  = bus.sel &  bus.we_n & ~bus.A[A_FLAGSEL];
    assign rd_flag_s = bus.sel &  bus.we_n &  bus.A[A_FLAGSEL];
    assign zero_s    = (count_q == {CNT_W{1'b0}});

    rriot_prescaler #(.PRE_W(PRE_W)) u_pre (
        .phi2   (phi2),
        .rst_n  (rst_n),
        .load_i (wr_s),
        .div_i  (div_sel_e'(bus.A[1:0])),
        .zero_i (zero_s),
        .step_o (step_s)
    );

    // Count, flag and enable registers with synchronous active-low reset.
    always_ff @(posedge phi2) begin
        if (!rst_n) begin
            count_q  <= {CNT_W{1'b0}};
            flag_q   <= 1'b0;
            irq_en_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            flag_q   <= flag_d;
            irq_en_q <= irq_en_d;
        end
    end

    // A write overrides everything; an underflow set beats a read-clear.
    always_comb begin
        count_d  = count_q;
        flag_d   = flag_q;
        irq_en_d = irq_en_q;
        if (wr_s) begin
            count_d  = CNT_W'(bus.DI);
            flag_d   = 1'b0;
            irq_en_d = bus.A[A_IRQEN];
        end else begin
            if (rd_tmr_s) begin
                flag_d   = 1'b0;
                irq_en_d = bus.A[A_IRQEN];
            end else begin
                irq_en_d = irq_en_q;
            end
            if (step_s) begin
                if (zero_s) begin
                    count_d = {CNT_W{1'b1}};
                    flag_d  = 1'b1;
                end else begin
                    count_d = count_q - CNT_W'(1);
                end
            end else begin
                count_d = count_q;
            end
        end
    end

    // Read mux; idle and write cycles return zero.
    always_comb begin
        bus.DO = 8'h00;
        if (rd_tmr_s) begin
            bus.DO = 8'(count_q);
        end else if (rd_flag_s) begin
            bus.DO = {flag_q, 7'b0000000};
        end else begin
            bus.DO = 8'h00;
        end
    end

    assign bus.IRQ    = ~(flag_q & irq_en_q);
    assign bus.IRQ_EN = irq_en_q;

endmodule

// File: tb/tb_rriot_timer.sv
// Self-checking bench for rriot_timer: vector table, directed corner-case
// sequences and a randomized run against a behavioural timer model.
module tb_rriot_timer;

    logic phi2;
    logic rst_n;
    rriot_timer_if bus ();

    rriot_timer #(.CNT_W(8), .PRE_W(10)) dut (
        .phi2  (phi2),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial phi2 = 1'b0;
    always #5 phi2 = ~phi2;

    int checks = 0;
    int errors = 0;
    logic [7:0] last_do;

    // Behavioural model: edges left until the next count step.
    int   m_count = 0;
    int   m_left  = 1;
    int   m_div   = 1;
    bit   m_post  = 0;
    bit   m_flag  = 0;
    bit   m_en    = 0;

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    function automatic int divisor(input logic [1:0] s);
        int d;
        case (s)
            2'd0:    d = 1;
            2'd1:    d = 8;
            2'd2:    d = 64;
            default: d = 1024;
        endcase
        return d;
    endfunction

    function automatic int model_do(input logic s, input logic w, input logic [3:0] a);
        if (!s || !w) return 0;
        if (a[0]) return m_flag ? 8'h80 : 8'h00;
        return m_count;
    endfunction

    task automatic model_edge(input logic s, input logic w, input logic [3:0] a,
                              input logic [7:0] d);
        if (!rst_n) begin
            m_count = 0; m_left = 1; m_div = 1; m_post = 0; m_flag = 0; m_en = 0;
        end else if (s && !w) begin
            m_count = d; m_div = divisor(a[1:0]); m_left = m_div;
            m_flag = 0; m_en = a[3]; m_post = 0;
        end else begin
            if (s && w && !a[0]) begin
                m_flag = 0; m_en = a[3];
            end
            m_left = m_left - 1;
            if (m_left == 0) begin
                if (m_count == 0) begin
                    m_count = 255; m_flag = 1; m_post = 1;
                end else begin
                    m_count = m_count - 1;
                end
                m_left = m_post ? 1 : m_div;
            end
        end
    endtask

    // One cycle: drive at negedge, sample DO, clock, check pins vs model.
    task automatic tick(input logic s, input logic w, input logic [3:0] a,
                        input logic [7:0] d);
        bus.sel = s; bus.we_n = w; bus.A = a; bus.DI = d;
        #1;
        last_do = bus.DO;
        chk("model_do", int'(last_do), model_do(s, w, a));
        @(posedge phi2);
        model_edge(s, w, a, d);
        @(negedge phi2);
        chk("model_irq", int'(bus.IRQ), int'(!(m_flag && m_en)));
        chk("model_irq_en", int'(bus.IRQ_EN), int'(m_en));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b1, 4'h0, 8'h00);
    endtask

    typedef struct {
        logic       sel;
        logic       we_n;
        logic [3:0] a;
        logic [7:0] di;
        logic [7:0] exp_do;
        logic       exp_irq;
        logic       exp_irq_en;
    } vec_t;

    vec_t tbl[10];

    initial begin
        tbl[0] = '{1'b1, 1'b0, 4'b1000, 8'h01, 8'h00, 1'b1, 1'b1};
        tbl[1] = '{1'b0, 1'b1, 4'b0000, 8'h00, 8'h00, 1'b1, 1'b1};
        tbl[2] = '{1'b1, 1'b1, 4'b1000, 8'h00, 8'h00, 1'b0, 1'b1};
        tbl[3] = '{1'b1, 1'b1, 4'b0001, 8'h00, 8'h80, 1'b0, 1'b1};
        tbl[4] = '{1'b1, 1'b1, 4'b0000, 8'h00, 8'hFE, 1'b1, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 4'b1000, 8'h00, 8'hFD, 1'b1, 1'b1};
        tbl[6] = '{1'b1, 1'b1, 4'b1001, 8'h00, 8'h00, 1'b1, 1'b1};
        tbl[7] = '{1'b1, 1'b0, 4'b0001, 8'h05, 8'h00, 1'b1, 1'b0};
        tbl[8] = '{1'b1, 1'b1, 4'b0100, 8'h00, 8'h05, 1'b1, 1'b0};
        tbl[9] = '{1'b0, 1'b0, 4'b0001, 8'h33, 8'h00, 1'b1, 1'b0};

        bus.sel = 1'b0; bus.we_n = 1'b1; bus.A = 4'h0; bus.DI = 8'h00;
        rst_n = 1'b0;
        @(negedge phi2);

        // Reset held three cycles, then released.
        idle(3);
        rst_n = 1'b1;
        chk("rst_irq", int'(bus.IRQ), 1);
        chk("rst_irq_en", int'(bus.IRQ_EN), 0);
        chk("rst_do_idle", int'(bus.DO), 0);
        tick(1'b1, 1'b1, 4'b0000, 8'h00);
        chk("rst_timer_read", int'(last_do), 8'h00);

        // Vector table.
        for (int i = 0; i < 10; i++) begin
            tick(tbl[i].sel, tbl[i].we_n, tbl[i].a, tbl[i].di);
            chk($sformatf("tbl%0d_do", i), int'(last_do), int'(tbl[i].exp_do));
            chk($sformatf("tbl%0d_irq", i), int'(bus.IRQ), int'(tbl[i].exp_irq));
            chk($sformatf("tbl%0d_irq_en", i), int'(bus.IRQ_EN), int'(tbl[i].exp_irq_en));
        end

        // Divide by 8, count 3, IRQ enabled.
        tick(1'b1, 1'b0, 4'b1001, 8'h03);
        idle(7);
        tick(1'b1, 1'b1, 4'b1000, 8'h00);
        chk("d8_hold", int'(last_do), 8'h03);
        tick(1'b1, 1'b1, 4'b1000, 8'h00);
        chk("d8_first_dec", int'(last_do), 8'h02);
        idle(22);
        tick(1'b1, 1'b1, 4'b1001, 8'h00);
        chk("d8_flag_before", int'(last_do), 8'h00);
        chk("d8_irq_low", int'(bus.IRQ), 0);
        tick(1'b1, 1'b1, 4'b1000, 8'h00);
        chk("d8_post_ff", int'(last_do), 8'hFF);
        tick(1'b1, 1'b1, 4'b1000, 8'h00);
        chk("d8_post_fe", int'(last_do), 8'hFE);
        chk("d8_irq_cleared", int'(bus.IRQ), 1);

        // Divide by 1024, count 2, no enable.
        tick(1'b1, 1'b0, 4'b0011, 8'h02);
        idle(3071);
        tick(1'b1, 1'b1, 4'b0001, 8'h00);
        chk("d1024_flag_early", int'(last_do), 8'h00);
        tick(1'b1, 1'b1, 4'b0001, 8'h00);
        chk("d1024_flag_set", int'(last_do), 8'h80);
        chk("d1024_irq_high", int'(bus.IRQ), 1);
        tick(1'b1, 1'b1, 4'b1000, 8'h00);
        chk("d1024_count", int'(last_do), 8'hFE);
        chk("d1024_en", int'(bus.IRQ_EN), 1);
        chk("d1024_irq_ack", int'(bus.IRQ), 1);

        // Underflow coincident with timer read: set wins.
        tick(1'b1, 1'b0, 4'b1000, 8'h00);
        tick(1'b1, 1'b1, 4'b1000, 8'h00);
        chk("coinc_do", int'(last_do), 8'h00);
        chk("coinc_irq", int'(bus.IRQ), 0);
        tick(1'b1, 1'b1, 4'b1001, 8'h00);
        chk("coinc_flag", int'(last_do), 8'h80);

        // Write on the exact underflow edge: write wins.
        tick(1'b1, 1'b0, 4'b1000, 8'h00);
        tick(1'b1, 1'b0, 4'b1000, 8'h10);
        chk("wr_vs_uf_irq", int'(bus.IRQ), 1);
        tick(1'b1, 1'b1, 4'b1000, 8'h00);
        chk("wr_vs_uf_count", int'(last_do), 8'h10);

        // Reset mid-count.
        tick(1'b1, 1'b0, 4'b1010, 8'h40);
        idle(100);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        chk("midrst_irq", int'(bus.IRQ), 1);
        chk("midrst_irq_en", int'(bus.IRQ_EN), 0);
        tick(1'b1, 1'b1, 4'b0001, 8'h00);
        chk("midrst_no_flag", int'(last_do), 8'h00);

        // Randomized traffic against the model.
        for (int i = 0; i < 2500; i++) begin
            int r;
            logic [3:0] a;
            logic [7:0] d;
            r = $urandom_range(0, 199);
            a = 4'($urandom);
            d = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            if (r < 12) begin
                a[1:0] = ($urandom_range(0, 9) == 0) ? 2'b10 : 2'($urandom_range(0, 1));
                tick(1'b1, 1'b0, a, d);
            end else if (r < 40) begin
                tick(1'b1, 1'b1, a, d);
            end else if (r == 40) begin
                rst_n = 1'b0;
                tick(1'b0, 1'($urandom), a, d);
                rst_n = 1'b1;
            end else begin
                tick(1'b0, 1'($urandom), a, d);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
